// File: rtl/ram_arb_pkg.sv
// Shared constants and state encoding for the two-port RAM arbiter.
// The optional RAM_ARB_ROUND_ROBIN_EN macro is consumed only by ram_arb_grant.
package ram_arb_pkg;

  localparam int DEFAULT_ADDR_W  = 11;
  localparam int DEFAULT_DATA_W  = 64;
  localparam int NUM_PORTS       = 2;
  localparam int RAM_LATENCY_MIN = 1;
  localparam int RAM_LATENCY_MAX = 15;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic bit latency_in_range(input int lat);
    return (lat >= RAM_LATENCY_MIN) && (lat <= RAM_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/ram_arb_grant.sv
// Combinational one-hot picker between the fetch (0) and data (1) ports.
// RAM_ARB_ROUND_ROBIN_EN selects alternating grants on contention; default is port 1 priority.
module ram_arb_grant (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end
`else
  // Fixed priority ignores history; keep the input visibly consumed.
  logic last_grant_unused;
  assign last_grant_unused = last_grant;

  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a single-port RAM between instruction fetch (port 0) and data (port 1).
// Grant policy follows RAM_ARB_ROUND_ROBIN_EN (see ram_arb_grant).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int RAM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          reqValid,
  output logic [1:0]          reqReady,
  input  logic [1:0]          reqWrite,
  input  logic [2*ADDR_W-1:0] reqAddr,
  input  logic [2*DATA_W-1:0] reqWData,
  output logic [1:0]          rspValid,
  output logic [DATA_W-1:0]   rspRData,
  output logic [ADDR_W-1:0]   ramAddress,
  output logic                ramIsReading,
  output logic [DATA_W-1:0]   ramDataIn,
  input  logic [DATA_W-1:0]   ramDataOut
);

  if (!latency_in_range(RAM_LATENCY)) begin : g_bad_latency
    $error("ram_arbiter: RAM_LATENCY must be within 1..15");
  end

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             write_reg;
  logic             id_reg;
  logic             last_grant_reg;
  logic [1:0]       grant;
  logic             sel;
  logic             accept;

  logic [ADDR_W-1:0] port_addr  [NUM_PORTS];
  logic [DATA_W-1:0] port_wdata [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign port_addr[gi]  = reqAddr[gi*ADDR_W +: ADDR_W];
    assign port_wdata[gi] = reqWData[gi*DATA_W +: DATA_W];
  end

  ram_arb_grant u_grant (
    .req_valid  (reqValid),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  // Grant is a subset of reqValid, so any ready bit in IDLE is a transfer.
  assign reqReady = (state_reg == IDLE) ? grant : 2'b00;
  assign accept   = |reqReady;
  assign sel      = grant[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      write_reg      <= 1'b0;
      id_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
      rspValid       <= 2'b00;
      rspRData       <= '0;
      ramAddress     <= '0;
      ramIsReading   <= 1'b1;
      ramDataIn      <= '0;
    end else begin
      rspValid <= 2'b00;
      case (state_reg)
        IDLE: begin
          ramIsReading <= 1'b1;
          if (accept) begin
            ramAddress     <= port_addr[sel];
            ramDataIn      <= port_wdata[sel];
            ramIsReading   <= ~reqWrite[sel];
            write_reg      <= reqWrite[sel];
            id_reg         <= sel;
            last_grant_reg <= sel;
            cnt_reg        <= CNT_W'(RAM_LATENCY - 1);
            state_reg      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            if (!write_reg) begin
              rspRData <= ramDataOut;
            end
            rspValid     <= id_reg ? 2'b10 : 2'b01;
            ramIsReading <= 1'b1;
            state_reg    <= RESP;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed requests push expected responses,
// a negedge monitor pops and checks them. Honours RAM_ARB_ROUND_ROBIN_EN for grant order.
module tb_ram_arbiter;
  parameter int RAM_LATENCY = 1;
  localparam int AW = 11;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    reqValid, reqReady, reqWrite, rspValid;
  logic [2*AW-1:0] reqAddr;
  logic [2*DW-1:0] reqWData;
  logic [DW-1:0] rspRData, ramDataIn, ramDataOut;
  logic [AW-1:0] ramAddress;
  logic          ramIsReading;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  typedef struct {
    int          port;
    bit          wr;
    logic [63:0] data;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  logic [63:0] ram_mem [2048];
  logic [63:0] ref_mem [2048];
  logic [63:0] last_rd;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(RAM_LATENCY)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqWData(reqWData),
    .rspValid(rspValid), .rspRData(rspRData),
    .ramAddress(ramAddress), .ramIsReading(ramIsReading),
    .ramDataIn(ramDataIn), .ramDataOut(ramDataOut)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // RAM instance model: combinational read, write on the clock edge.
  assign ramDataOut = ram_mem[ramAddress];
  always @(posedge clk) if (!ramIsReading) ram_mem[ramAddress] <= ramDataIn;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    chk("ready_onehot", 64'(reqReady == 2'b11), 64'd0);
    if (rspValid !== 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(rspValid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_port", 64'(rspValid), (e.port == 1) ? 64'd2 : 64'd1);
        chk("rsp_latency", 64'(cycle - e.acc), 64'(RAM_LATENCY + 1));
        if (!e.wr) last_rd = e.data;
        chk(e.wr ? "rsp_data_held" : "rsp_rdata", rspRData, last_rd);
        $display("rsp port=%0d wr=%0d data=%0h cycle=%0d", e.port, e.wr, rspRData, cycle);
      end
    end
  end

  task automatic issue(input int p, input bit w, input logic [10:0] a,
                       input logic [63:0] d, input bit track, output int acc);
    int n;
    exp_t e;
    reqValid[p] = 1'b1;
    reqWrite[p] = w;
    reqAddr[p*AW +: AW] = a;
    reqWData[p*DW +: DW] = d;
    #1;
    n = 0;
    while (!reqReady[p] && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("accept", 64'(reqReady[p]), 64'd1);
    acc = cycle;
    if (track) begin
      e.port = p; e.wr = w; e.data = ref_mem[a]; e.acc = cycle;
      exp_q.push_back(e);
      if (w) ref_mem[a] = d;
    end
    $display("req port=%0d wr=%0d addr=%0d data=%0h cycle=%0d", p, w, a, d, cycle);
    @(negedge clk);
    reqValid[p] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_reqReady"}, 64'(reqReady), 64'd0);
    chk({tag, "_rspValid"}, 64'(rspValid), 64'd0);
    chk({tag, "_rspRData"}, rspRData, 64'd0);
    chk({tag, "_ramAddress"}, 64'(ramAddress), 64'd0);
    chk({tag, "_ramIsReading"}, 64'(ramIsReading), 64'd1);
    chk({tag, "_ramDataIn"}, ramDataIn, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, z, n, k, p, prev;
    int exp_grant [6];
    for (int i = 0; i < 2048; i++) begin
      ram_mem[i] = 64'd0;
      ref_mem[i] = 64'd0;
    end
    last_rd  = 64'd0;
    reset    = 1'b1;
    reqValid = 2'b00; reqWrite = 2'b00; reqAddr = '0; reqWData = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: port 1 write, write strobe only during the access window
    issue(1, 1'b1, 11'd1024, 64'hff04, 1'b1, acc);
    z = 0;
    for (int i = 0; i < RAM_LATENCY + 2; i++) begin
      if (!ramIsReading) z++;
      @(negedge clk);
    end
    chk("write_window", 64'(z), 64'(RAM_LATENCY));
    drain();

    // 2: port 0 reads, zero then written value
    issue(0, 1'b0, 11'd1023, 64'd0, 1'b1, acc);
    issue(0, 1'b0, 11'd1024, 64'd0, 1'b1, acc);
    drain();

    // 3: contention; a port-1 write first so the RR history favours port 0
    issue(1, 1'b1, 11'd7, 64'h1111, 1'b1, acc);
    drain();
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_grant = '{0, 1, 0, 1, 0, 1};
`else
    exp_grant = '{1, 1, 1, 1, 1, 1};
`endif
    reqValid = 2'b11; reqWrite = 2'b00;
    reqAddr = {11'd7, 11'd1024};
    #1;
    k = 0; n = 0;
    while (k < 6 && n < 6 * (RAM_LATENCY + 2) + 20) begin
      if (reqReady != 2'b00) begin
        exp_t e;
        p = reqReady[1] ? 1 : 0;
        chk("grant_order", 64'(p), 64'(exp_grant[k]));
        e.port = p; e.wr = 1'b0; e.data = ref_mem[p == 1 ? 7 : 1024]; e.acc = cycle;
        exp_q.push_back(e);
        $display("contend grant=%0d idx=%0d cycle=%0d", p, k, cycle);
        k++;
      end
      @(negedge clk); #1; n++;
    end
    reqValid = 2'b00;
    chk("contend_count", 64'(k), 64'd6);
    drain();

    // 4: port 0 pulse outside IDLE is ignored, then accepted in IDLE
    issue(1, 1'b0, 11'd1024, 64'd0, 1'b1, acc);
    reqValid[0] = 1'b1; reqWrite[0] = 1'b0;
    #1;
    chk("ready_in_access", 64'(reqReady), 64'd0);
    @(negedge clk);
    reqValid[0] = 1'b0;
    drain();
    issue(0, 1'b0, 11'd7, 64'd0, 1'b1, acc);
    drain();

    // 5: reset mid-ACCESS aborts the write with no response
    issue(1, 1'b1, 11'd5, 64'hdead, 1'b0, acc);
    if (RAM_LATENCY > 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("midreset");
    last_rd = 64'd0;
    repeat (RAM_LATENCY + 3) @(negedge clk);
    issue(1, 1'b1, 11'd6, 64'h77, 1'b1, acc);
    issue(1, 1'b0, 11'd6, 64'd0, 1'b1, acc);
    drain();

    // 6: held port-0 reads, accepts spaced RAM_LATENCY+2 apart
    reqValid[0] = 1'b1; reqWrite[0] = 1'b0;
    reqAddr[0 +: AW] = 11'd1024;
    #1;
    k = 0; prev = -1;
    for (int i = 0; i < 3 * (RAM_LATENCY + 2); i++) begin
      if (reqReady[0]) begin
        exp_t e;
        if (prev >= 0) chk("accept_spacing", 64'(cycle - prev), 64'(RAM_LATENCY + 2));
        prev = cycle;
        e.port = 0; e.wr = 1'b0; e.data = ref_mem[1024]; e.acc = cycle;
        exp_q.push_back(e);
        $display("held accept idx=%0d cycle=%0d", k, cycle);
        k++;
      end
      @(negedge clk);
      if (i != 3 * (RAM_LATENCY + 2) - 1) #1;
    end
    reqValid[0] = 1'b0;
    chk("held_accepts", 64'(k), 64'd3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
